// File: rtl/keypad_scanner.sv
// keypad_scanner: column-multiplexed matrix keypad scanner with frame-level
// debounce, optional auto-repeat and a valid/ready key event output.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DWELL    = 16,
    parameter int DEBOUNCE = 3,
    parameter int REPEAT   = 0,
    localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_release,
    output logic              key_overrun
);

    localparam int COL_W    = $clog2(COLS);
    localparam int DW_W     = $clog2(DWELL);
    localparam int CNT_W    = $clog2(DEBOUNCE + 1);
    localparam int REP_W    = $clog2(REPEAT + 2);
    localparam int REP_LAST = (REPEAT > 0) ? REPEAT - 1 : 0;

    typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_t;
    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD} state_t;

    logic [COL_W-1:0]  col;
    logic [DW_W-1:0]   dwell;
    frame_t            acc_kind;
    logic [CODE_W-1:0] acc_code;
    frame_t            cur_kind;
    logic [CODE_W-1:0] cur_code;
    frame_t            frame_kind;
    logic [CODE_W-1:0] frame_code;
    logic              frame_valid;
    logic              sample;
    logic              last_col;

    state_t            state;
    logic [CODE_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rel;
    logic [REP_W-1:0]  rep;
    logic              match;
    logic              issue;

    assign sample   = (dwell == DW_W'(DWELL - 1));
    assign last_col = (col == COL_W'(COLS - 1));

    // Column drive: one-hot on the current column, all low while disabled.
    always_comb begin
        col_out = '0;
        if (enable) begin
            col_out = COLS'(1) << col;
        end
    end

    // Merge the rows of the current column into the partial frame result.
    always_comb begin
        int unsigned       hits;
        int unsigned       hit_row;
        logic [ROWS-1:0]   bits;
        hits     = 0;
        hit_row  = 0;
        bits     = '0;
        cur_kind = acc_kind;
        cur_code = acc_code;
        for (int unsigned r = 0; r < ROWS; r++) begin
            bits = row_in >> r;
            if (bits[0]) begin
                hits    = hits + 1;
                hit_row = r;
            end
        end
        case (acc_kind)
            FR_NONE: begin
                if (hits == 1) begin
                    cur_kind = FR_SINGLE;
                    cur_code = CODE_W'(hit_row * COLS + int'(col));
                end else if (hits > 1) begin
                    cur_kind = FR_MULTI;
                end
            end
            FR_SINGLE: begin
                if (hits > 0) begin
                    cur_kind = FR_MULTI;
                end
            end
            default: cur_kind = FR_MULTI;
        endcase
    end

    // Column/dwell sequencing and frame accumulation; one-cycle frame strobe.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            col         <= '0;
            dwell       <= '0;
            acc_kind    <= FR_NONE;
            acc_code    <= '0;
            frame_valid <= 1'b0;
            if (reset) begin
                frame_kind <= FR_NONE;
                frame_code <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            if (sample) begin
                dwell <= '0;
                if (last_col) begin
                    col         <= '0;
                    acc_kind    <= FR_NONE;
                    acc_code    <= '0;
                    frame_valid <= 1'b1;
                    frame_kind  <= cur_kind;
                    frame_code  <= cur_code;
                end else begin
                    col      <= col + 1'b1;
                    acc_kind <= cur_kind;
                    acc_code <= cur_code;
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign match = (frame_kind == FR_SINGLE) && (frame_code == cand);

    // Decide whether the frame just completed produces a key event.
    always_comb begin
        issue = 1'b0;
        if (enable && frame_valid) begin
            case (state)
                S_IDLE:  issue = (frame_kind == FR_SINGLE) && (DEBOUNCE == 1);
                S_DEB:   issue = match && (cnt == CNT_W'(DEBOUNCE - 1));
                S_HELD:  issue = (REPEAT > 0) && match && (rep == REP_W'(REP_LAST));
                default: issue = 1'b0;
            endcase
        end
    end

    // Debounce/repeat FSM and key handshake; everything frozen while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cand        <= '0;
            cnt         <= '0;
            rel         <= '0;
            rep         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            key_release <= 1'b0;
            key_overrun <= 1'b0;
            if (enable) begin
                if (key_valid && key_ready) begin
                    key_valid <= 1'b0;
                end
                // A new event landing on an accept edge reloads rather than overruns.
                if (issue) begin
                    if (key_valid && !key_ready) begin
                        key_overrun <= 1'b1;
                    end else begin
                        key_code  <= frame_code;
                        key_valid <= 1'b1;
                    end
                end
                if (frame_valid) begin
                    case (state)
                        S_IDLE: begin
                            if (frame_kind == FR_SINGLE) begin
                                cand <= frame_code;
                                if (DEBOUNCE == 1) begin
                                    state <= S_HELD;
                                    rel   <= '0;
                                    rep   <= '0;
                                end else begin
                                    cnt   <= CNT_W'(1);
                                    state <= S_DEB;
                                end
                            end
                        end
                        S_DEB: begin
                            if (match) begin
                                if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                                    state <= S_HELD;
                                    cnt   <= '0;
                                    rel   <= '0;
                                    rep   <= '0;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end else if (frame_kind == FR_SINGLE) begin
                                cand <= frame_code;
                                cnt  <= CNT_W'(1);
                            end else begin
                                state <= S_IDLE;
                                cnt   <= '0;
                            end
                        end
                        S_HELD: begin
                            if (frame_kind == FR_NONE) begin
                                if (rel == CNT_W'(DEBOUNCE - 1)) begin
                                    key_release <= 1'b1;
                                    state       <= S_IDLE;
                                    rel         <= '0;
                                    rep         <= '0;
                                end else begin
                                    rel <= rel + 1'b1;
                                end
                            end else begin
                                rel <= '0;
                                if (match && (REPEAT > 0)) begin
                                    rep <= (rep == REP_W'(REP_LAST)) ? '0 : rep + 1'b1;
                                end else if (!match) begin
                                    rep <= '0;
                                end
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x4 matrix, DWELL=4 (16-cycle frames),
// DEBOUNCE=3; a second instance with REPEAT=4 covers auto-repeat and enable.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        enable1 = 1'b1;
    logic [3:0]  row1;
    logic [3:0]  col1;
    logic [3:0]  code1;
    logic        valid1;
    logic        ready1 = 1'b0;
    logic        rel1;
    logic        ovr1;
    logic [15:0] keys1 = '0;

    logic        enable2 = 1'b1;
    logic [3:0]  row2;
    logic [3:0]  col2;
    logic [3:0]  code2;
    logic        valid2;
    logic        ready2 = 1'b1;
    logic        rel2;
    logic        ovr2;
    logic [15:0] keys2 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(3), .REPEAT(0)) dut1 (
        .clock(clk), .reset(reset), .enable(enable1), .row_in(row1), .col_out(col1),
        .key_code(code1), .key_valid(valid1), .key_ready(ready1),
        .key_release(rel1), .key_overrun(ovr1)
    );

    keypad_scanner #(.ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(3), .REPEAT(4)) dut2 (
        .clock(clk), .reset(reset), .enable(enable2), .row_in(row2), .col_out(col2),
        .key_code(code2), .key_valid(valid2), .key_ready(ready2),
        .key_release(rel2), .key_overrun(ovr2)
    );

    // Physical keypad: key r*4+c connects column c to row r.
    always_comb begin
        row1 = '0;
        row2 = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys1[r*4+c] && col1[c]) row1[r] = 1'b1;
                if (keys2[r*4+c] && col2[c]) row2[r] = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this the next rising edge is edge 1 of the first frame.
    task automatic apply_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        keys1 = '0;
        reset = 1'b1;
        tick(2);
        n_cmp++; if (col1 !== 4'b0001) begin n_bad++; $display("FAIL reset_col: got %b want 0001", col1); end
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid1); end
        n_cmp++; if (code1 !== 4'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", code1); end
        n_cmp++; if (rel1 !== 1'b0 || ovr1 !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got rel=%b ovr=%b want 0 0", rel1, ovr1); end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp = 4'b0001 << ((k / 4) % 4);
            n_cmp++; if (col1 !== exp) begin n_bad++; $display("FAIL col_cycle k=%0d: got %b want %b", k, col1, exp); end
        end
    endtask

    task automatic test_press();
        logic ok;
        logic found;
        keys1 = 16'h0001 << 9;
        ready1 = 1'b0;
        apply_reset();
        tick(48);
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL press_early: got %b want 0", valid1); end
        tick(1);
        n_cmp++; if (valid1 !== 1'b1) begin n_bad++; $display("FAIL press_valid: got %b want 1", valid1); end
        n_cmp++; if (code1 !== 4'd9) begin n_bad++; $display("FAIL press_code: got %0d want 9", code1); end
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (valid1 !== 1'b1 || code1 !== 4'd9 || ovr1 !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL press_hold: got valid=%b code=%0d want 1 9", valid1, code1); end
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL press_accept: got %b want 0", valid1); end
        keys1 = '0;
        found = 1'b0;
        for (int i = 0; i < 66 && !found; i++) begin
            tick(1);
            if (rel1 === 1'b1) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL press_release_timeout: got none want pulse within 66 cycles"); end
        tick(1);
        n_cmp++; if (rel1 !== 1'b0) begin n_bad++; $display("FAIL press_release_width: got %b want 0", rel1); end
    endtask

    task automatic test_bounce();
        keys1 = 16'h0001 << 9;
        apply_reset();
        tick(32);
        keys1 = '0;
        tick(16);
        keys1 = 16'h0001 << 9;
        tick(33);
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL bounce_no_event: got %b want 0", valid1); end
        tick(15);
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL bounce_early: got %b want 0", valid1); end
        tick(1);
        n_cmp++; if (valid1 !== 1'b1 || code1 !== 4'd9) begin n_bad++; $display("FAIL bounce_event: got valid=%b code=%0d want 1 9", valid1, code1); end
    endtask

    task automatic test_multi_release();
        logic quiet;
        keys1 = (16'h0001 << 5) | (16'h0001 << 6);
        ready1 = 1'b0;
        apply_reset();
        tick(65);
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL multi_no_event: got %b want 0", valid1); end
        keys1 = 16'h0001 << 5;
        tick(47);
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", valid1); end
        tick(1);
        n_cmp++; if (valid1 !== 1'b1 || code1 !== 4'd5) begin n_bad++; $display("FAIL single_event: got valid=%b code=%0d want 1 5", valid1, code1); end
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
        n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL single_accept: got %b want 0", valid1); end
        quiet = 1'b1;
        keys1 = '0;
        for (int i = 0; i < 30; i++) begin tick(1); if (rel1 !== 1'b0) quiet = 1'b0; end
        keys1 = 16'h0001 << 5;
        for (int i = 0; i < 16; i++) begin tick(1); if (rel1 !== 1'b0) quiet = 1'b0; end
        keys1 = '0;
        for (int i = 0; i < 48; i++) begin tick(1); if (rel1 !== 1'b0) quiet = 1'b0; end
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL release_bounce: got early pulse want none before restart"); end
        tick(1);
        n_cmp++; if (rel1 !== 1'b1) begin n_bad++; $display("FAIL release_pulse: got %b want 1", rel1); end
        n_cmp++; if (code1 !== 4'd5 || valid1 !== 1'b0) begin n_bad++; $display("FAIL release_code: got code=%0d valid=%b want 5 0", code1, valid1); end
        tick(1);
        n_cmp++; if (rel1 !== 1'b0) begin n_bad++; $display("FAIL release_width: got %b want 0", rel1); end
    endtask

    task automatic test_overrun();
        keys1 = 16'h0001 << 5;
        ready1 = 1'b0;
        apply_reset();
        tick(49);
        n_cmp++; if (valid1 !== 1'b1 || code1 !== 4'd5) begin n_bad++; $display("FAIL ovr_first: got valid=%b code=%0d want 1 5", valid1, code1); end
        keys1 = '0;
        tick(48);
        n_cmp++; if (rel1 !== 1'b1) begin n_bad++; $display("FAIL ovr_release: got %b want 1", rel1); end
        keys1 = 16'h0001 << 6;
        tick(47);
        n_cmp++; if (ovr1 !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b want 0", ovr1); end
        tick(1);
        n_cmp++; if (ovr1 !== 1'b1) begin n_bad++; $display("FAIL ovr_pulse: got %b want 1", ovr1); end
        n_cmp++; if (valid1 !== 1'b1 || code1 !== 4'd5) begin n_bad++; $display("FAIL ovr_keep: got valid=%b code=%0d want 1 5", valid1, code1); end
        tick(1);
        n_cmp++; if (ovr1 !== 1'b0) begin n_bad++; $display("FAIL ovr_width: got %b want 0", ovr1); end
    endtask

    task automatic test_repeat_enable();
        logic quiet;
        keys2 = 16'h0001;
        ready2 = 1'b1;
        enable2 = 1'b1;
        apply_reset();
        tick(49);
        n_cmp++; if (valid2 !== 1'b1 || code2 !== 4'd0) begin n_bad++; $display("FAIL rep_first: got valid=%b code=%0d want 1 0", valid2, code2); end
        tick(1);
        n_cmp++; if (valid2 !== 1'b0) begin n_bad++; $display("FAIL rep_accept: got %b want 0", valid2); end
        tick(62);
        n_cmp++; if (valid2 !== 1'b0) begin n_bad++; $display("FAIL rep_early1: got %b want 0", valid2); end
        tick(1);
        n_cmp++; if (valid2 !== 1'b1 || code2 !== 4'd0) begin n_bad++; $display("FAIL rep_second: got valid=%b code=%0d want 1 0", valid2, code2); end
        tick(63);
        n_cmp++; if (valid2 !== 1'b0) begin n_bad++; $display("FAIL rep_early2: got %b want 0", valid2); end
        tick(1);
        n_cmp++; if (valid2 !== 1'b1) begin n_bad++; $display("FAIL rep_third: got %b want 1", valid2); end
        tick(3);
        enable2 = 1'b0;
        #1;
        n_cmp++; if (col2 !== 4'b0000) begin n_bad++; $display("FAIL dis_col: got %b want 0000", col2); end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (valid2 !== 1'b0 || col2 !== 4'b0000) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL dis_quiet: got valid=%b col=%b want 0 0000", valid2, col2); end
        enable2 = 1'b1;
        #1;
        n_cmp++; if (col2 !== 4'b0001) begin n_bad++; $display("FAIL reen_col0: got %b want 0001", col2); end
        tick(3);
        n_cmp++; if (col2 !== 4'b0001) begin n_bad++; $display("FAIL reen_dwell: got %b want 0001", col2); end
        tick(1);
        n_cmp++; if (col2 !== 4'b0010) begin n_bad++; $display("FAIL reen_col1: got %b want 0010", col2); end
        ready2 = 1'b0;
        tick(60);
        n_cmp++; if (valid2 !== 1'b0) begin n_bad++; $display("FAIL reen_early: got %b want 0", valid2); end
        tick(1);
        n_cmp++; if (valid2 !== 1'b1) begin n_bad++; $display("FAIL reen_repeat: got %b want 1", valid2); end
        tick(2);
        n_cmp++; if (valid2 !== 1'b1) begin n_bad++; $display("FAIL reen_hold: got %b want 1", valid2); end
        reset = 1'b1;
        tick(1);
        n_cmp++; if (valid2 !== 1'b0 || code2 !== 4'd0) begin n_bad++; $display("FAIL midreset: got valid=%b code=%0d want 0 0", valid2, code2); end
        n_cmp++; if (col2 !== 4'b0001) begin n_bad++; $display("FAIL midreset_col: got %b want 0001", col2); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_multi_release();
        test_overrun();
        test_repeat_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the calculator front end, successor to the fixed 4x4 keyboard decoder. It drives one column at a time with a configurable dwell, samples the row lines and reduces each full scan to a frame result. Key presses and releases are debounced over whole frames, with optional auto-repeat. Each debounced key is delivered as a linear key code through a valid/ready handshake to the calculator control logic.

## Interface
Parameters:
- ROWS, 4: number of row lines, 1..8.
- COLS, 4: number of column lines, 2..8.
- DWELL, 16: cycles each column is driven before its rows are sampled, ≥2.
- DEBOUNCE, 3: consecutive identical frames needed to accept a press or a release, ≥1.
- REPEAT, 0: auto-repeat period in frames while a key is held. 0 disables auto-repeat.
- CODE_W, derived: max(1, clog2(ROWS*COLS)).

Ports:
- clock, in, 1: single system clock. All logic uses the rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: scanning enabled.
- row_in, in, ROWS: row sense lines. 1 means a key is closed in the currently driven column. Already synchronised externally.
- col_out, out, COLS: one-hot active-high column drive.
- key_code, out, CODE_W: accepted key code, row*COLS + col.
- key_valid, out, 1: key event pending.
- key_ready, in, 1: consumer accepts the event.
- key_release, out, 1: one-cycle pulse when the held key is released (debounced).
- key_overrun, out, 1: one-cycle pulse when an event is dropped because key_valid is still high.

## Operation
Scan:
- A column index and a dwell counter advance while enable=1.
- col_out = enable ? onehot(col) : 0.
- row_in is sampled on the dwell count DWELL-1 of each column. The column index then advances, wrapping from COLS-1 to 0.
- A frame accumulates over columns 0..COLS-1. The frame result is one of:
  - NONE: no row bit set in any column.
  - SINGLE(code): exactly one bit set across the whole frame.
  - MULTI: two or more bits set. MULTI counts as "pressed but unusable".
- enable=0 freezes the FSM, debounce counters and key outputs. The column index, dwell counter and partial frame are cleared. Scanning restarts at column 0 with a fresh frame.

FSM, evaluated once per completed frame:
- IDLE:
  - SINGLE(c) → cand=c, cnt=1, then DEB. If DEBOUNCE=1, issue the event immediately and go to HELD.
  - NONE or MULTI → stay in IDLE.
- DEB:
  - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE, issue the event and go to HELD.
  - SINGLE(other) → cand=other, cnt=1.
  - NONE or MULTI → IDLE.
- HELD:
  - NONE → rel+1. When rel reaches DEBOUNCE, pulse key_release and go to IDLE.
  - SINGLE or MULTI → rel=0.
  - If REPEAT>0, SINGLE(cand) also increments rep. When rep reaches REPEAT, issue the event again and set rep=0.
  - MULTI or SINGLE(other) clears rep.

Issue event:
- If key_valid=0: key_code=cand and key_valid=1.
- Otherwise: key_code is unchanged and key_overrun pulses.

Handshake:
- key_valid stays high, and key_code stays stable, until an edge where key_ready=1. key_valid clears on that edge.
- An issue on the same edge as an accept loads the new code and keeps key_valid=1. This is not an overrun.
- key_release does not depend on key_ready. key_code still shows the last accepted key.

## Timing
Reset values: col index 0, dwell 0, FSM IDLE, all counters 0, key_code=0, key_valid=0, key_release=0, key_overrun=0. col_out=onehot(0) when enable=1, otherwise 0.

Frame length and event latency:
- F = COLS*DWELL cycles.
- The frame result is registered on the edge that samples column COLS-1.
- The FSM acts on the following edge. key_valid, key_release and key_overrun rise one cycle after the frame-end edge.

Press latency:
- Press latency from a stable press ≤ (DEBOUNCE+1)*F+2 cycles.
- Release latency has the same bound.

Reset mid-frame or mid-handshake:
- All state and outputs return to reset values on the next edge.
- A pending key_valid is lost.

## Test plan
Common setting: ROWS=4, COLS=4, DWELL=4, DEBOUNCE=3, REPEAT=0, so F=16.

1. Reset with enable=1 → col_out=4'b0001 and all key outputs 0. Columns then cycle 0001→0010→0100→1000→0001, each held 4 cycles.
2. Stable press at row 2, col 1, with key_ready=0:
   - key_valid rises one cycle after the 3rd full matching frame, with key_code=9.
   - key_valid holds for 100 cycles.
   - A single key_ready=1 cycle clears it on that edge.
3. Bounce:
   - Press for 2 frames, NONE for 1 frame, then press for 2 frames → no event.
   - The 3rd consecutive pressed frame raises key_valid with key_code=9.
4. Simultaneous code 5 and code 6 pressed → MULTI, no event.
   - Release code 6 → key_code=5 after 3 SINGLE frames.
   - While HELD, one bouncing pressed frame during release restarts the release count. key_release pulses only after 3 consecutive NONE frames.
5. Overrun: code 5 is issued and not accepted, then released, then code 6 is pressed → key_overrun pulses for 1 cycle, and key_code=5 with key_valid=1 are unchanged.
6. REPEAT=4, code 0 held, key_ready=1:
   - The first event is followed by repeat events every 64 cycles.
   - enable=0 mid-frame → col_out=0 and no events. Re-enable → scanning restarts at col 0.
   - Reset asserted while key_valid=1 → key_valid=0 on the next edge.
